// File: rtl/tawas_irom.sv
// rtl/tawas_irom.sv - Tawas instruction memory with 1-cycle fetch reads and a streaming program-load port
// Core is held off via core_hold while an image is streamed in.
module tawas_irom #(
  parameter int DEPTH_LOG2 = 12,
  parameter int BOOT_LOAD  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ics,
  input  logic [23:0] iaddr,
  output logic [31:0] idata,
  input  logic        ld_start,
  input  logic [23:0] ld_base,
  input  logic        ld_vld,
  input  logic        ld_last,
  input  logic [31:0] ld_data,
  output logic        ld_rdy,
  output logic        ld_done,
  output logic        ld_ovf,
  output logic        core_hold
);

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [31:0] NOP_OP  = 32'hC000_0000;

  typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;
  localparam state_t RST_STATE = (BOOT_LOAD != 0) ? LOAD : RUN;

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [23:0] wr_ptr_q, wr_ptr_d;
  logic        ld_ovf_q, ld_ovf_d;
  logic [31:0] idata_q, idata_d;

  logic        mem_we;
  logic        wr_in_range;
  logic        rd_in_range;

  assign wr_in_range = (wr_ptr_q[23:DEPTH_LOG2] == '0);
  assign rd_in_range = (iaddr[23:DEPTH_LOG2] == '0);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    ld_ovf_d = ld_ovf_q;
    mem_we   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ld_start) begin
          state_d  = LOAD;
          wr_ptr_d = ld_base;
          ld_ovf_d = 1'b0;
        end
      end
      LOAD: begin
        if (ld_vld) begin
          // Beats past the end of memory still advance the pointer.
          if (wr_in_range) mem_we = 1'b1;
          else             ld_ovf_d = 1'b1;
          wr_ptr_d = wr_ptr_q + 24'd1;
          if (ld_last) state_d = DONE;
        end
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Reads outside RUN park the core on a NOP loop, so fetch never races a write.
  always_comb begin
    idata_d = idata_q;
    if (ics) begin
      if ((state_q == RUN) && rd_in_range) idata_d = mem[iaddr[DEPTH_LOG2-1:0]];
      else                                 idata_d = NOP_OP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      wr_ptr_q <= '0;
      ld_ovf_q <= 1'b0;
      idata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      ld_ovf_q <= ld_ovf_d;
      idata_q  <= idata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= ld_data;
  end

  assign idata     = idata_q;
  assign ld_ovf    = ld_ovf_q;
  assign ld_rdy    = (state_q == LOAD);
  assign ld_done   = (state_q == DONE);
  assign core_hold = (state_q != RUN);

endmodule

// File: tb/tb_tawas_irom.sv
// tb/tb_tawas_irom.sv - self-checking bench for tawas_irom (run-mode and boot-load instances)
module tb_tawas_irom;

  localparam logic [31:0] NOP_OP = 32'hC000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: BOOT_LOAD=0
  logic        rst = 1'b1, ics = 1'b0, ld_start = 1'b0, ld_vld = 1'b0, ld_last = 1'b0;
  logic [23:0] iaddr = '0, ld_base = '0;
  logic [31:0] ld_data = '0, idata;
  logic        ld_rdy, ld_done, ld_ovf, core_hold;

  // Instance B: BOOT_LOAD=1
  logic        rst_b = 1'b1, ics_b = 1'b0, ld_start_b = 1'b0, ld_vld_b = 1'b0, ld_last_b = 1'b0;
  logic [23:0] iaddr_b = '0, ld_base_b = '0;
  logic [31:0] ld_data_b = '0, idata_b;
  logic        ld_rdy_b, ld_done_b, ld_ovf_b, core_hold_b;

  tawas_irom #(.DEPTH_LOG2(4), .BOOT_LOAD(0)) dut_a (
    .clk(clk), .rst(rst), .ics(ics), .iaddr(iaddr), .idata(idata),
    .ld_start(ld_start), .ld_base(ld_base), .ld_vld(ld_vld), .ld_last(ld_last),
    .ld_data(ld_data), .ld_rdy(ld_rdy), .ld_done(ld_done), .ld_ovf(ld_ovf),
    .core_hold(core_hold)
  );

  tawas_irom #(.DEPTH_LOG2(4), .BOOT_LOAD(1)) dut_b (
    .clk(clk), .rst(rst_b), .ics(ics_b), .iaddr(iaddr_b), .idata(idata_b),
    .ld_start(ld_start_b), .ld_base(ld_base_b), .ld_vld(ld_vld_b), .ld_last(ld_last_b),
    .ld_data(ld_data_b), .ld_rdy(ld_rdy_b), .ld_done(ld_done_b), .ld_ovf(ld_ovf_b),
    .core_hold(core_hold_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference image of instance A: 16 words, addresses >= 16 read back as the NOP loop.
  logic [31:0] model_mem [16];
  int          vld_pat [$];

  typedef struct {
    logic [23:0] addr;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [23:0] a);
    if (a < 24'd16) return model_mem[a[3:0]];
    return NOP_OP;
  endfunction

  task automatic read_a(input logic [23:0] a, input string name);
    ics = 1'b1; iaddr = a;
    step();
    ics = 1'b0;
    chk(name, idata, exp_read(a));
  endtask

  // Stream n beats into instance A starting at base; stalls come from vld_pat, else random.
  task automatic load_a(input logic [23:0] base, input int n, input int stall_pct, input bit start_mid);
    logic [23:0] ptr;
    logic        exp_ovf;
    logic        vld;
    logic [31:0] d;
    int          i;
    int          guard;
    ld_start = 1'b1; ld_base = base; ics = 1'b0;
    step();
    ld_start = 1'b0;
    chk("load_enter_ovf_clear", {31'd0, ld_ovf}, 32'd0);
    chk("load_enter_rdy", {31'd0, ld_rdy}, 32'd1);
    chk("load_enter_hold", {31'd0, core_hold}, 32'd1);
    ptr = base; exp_ovf = 1'b0; i = 0; guard = 0;
    while (i < n) begin
      if (vld_pat.size() > 0) vld = (vld_pat.pop_front() != 0);
      else                    vld = ($urandom_range(99) >= stall_pct);
      d = $urandom;
      ld_vld = vld; ld_data = d; ld_last = vld && (i == n - 1);
      ld_start = start_mid ? 1'($urandom_range(1)) : 1'b0;
      ld_base = 24'($urandom);
      ics = 1'b1; iaddr = 24'($urandom_range(15));
      step();
      if (vld) begin
        if (ptr < 24'd16) model_mem[ptr[3:0]] = d;
        else              exp_ovf = 1'b1;
        ptr = ptr + 24'd1;
        i++;
      end
      chk("read_during_load_nop", idata, NOP_OP);
      if (i < n) chk("no_early_done", {31'd0, ld_done}, 32'd0);
      guard++;
      if (guard > 500) begin
        chk("load_cycle_budget", 32'd1, 32'd0);
        break;
      end
    end
    ld_vld = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
    chk("done_pulse", {31'd0, ld_done}, 32'd1);
    chk("done_rdy_low", {31'd0, ld_rdy}, 32'd0);
    chk("done_hold", {31'd0, core_hold}, 32'd1);
    chk("done_ovf", {31'd0, ld_ovf}, {31'd0, exp_ovf});
    ics = 1'b1; iaddr = 24'd0;
    step();
    chk("read_in_done_nop", idata, NOP_OP);
    chk("done_one_cycle", {31'd0, ld_done}, 32'd0);
    chk("hold_released", {31'd0, core_hold}, 32'd0);
    chk("ovf_sticky", {31'd0, ld_ovf}, {31'd0, exp_ovf});
    read_a(24'($urandom_range(15)), "first_run_read");
  endtask

  initial begin
    // ---------------- Instance B: boot load ----------------
    step();
    rst_b = 1'b0;
    chk("b_reset_hold", {31'd0, core_hold_b}, 32'd1);
    chk("b_reset_rdy", {31'd0, ld_rdy_b}, 32'd1);
    chk("b_reset_done", {31'd0, ld_done_b}, 32'd0);
    chk("b_reset_idata", idata_b, 32'd0);
    ld_vld_b = 1'b1; ld_data_b = 32'h1111_1111; step();
    ld_last_b = 1'b1; ld_data_b = 32'h2222_2222; step();
    ld_vld_b = 1'b0; ld_last_b = 1'b0;
    chk("b_done_pulse", {31'd0, ld_done_b}, 32'd1);
    step();
    chk("b_hold_released", {31'd0, core_hold_b}, 32'd0);
    ics_b = 1'b1; iaddr_b = 24'd0; step();
    chk("b_mem0", idata_b, 32'h1111_1111);
    iaddr_b = 24'd1; step();
    chk("b_mem1", idata_b, 32'h2222_2222);
    ics_b = 1'b0;
    ld_start_b = 1'b1; ld_base_b = 24'd8; step();
    ld_start_b = 1'b0;
    ld_vld_b = 1'b1; ld_data_b = 32'h3333_3333; step();
    ld_vld_b = 1'b0;
    rst_b = 1'b1; step();
    rst_b = 1'b0;
    chk("b_abort_rdy", {31'd0, ld_rdy_b}, 32'd1);
    chk("b_abort_hold", {31'd0, core_hold_b}, 32'd1);
    chk("b_abort_done", {31'd0, ld_done_b}, 32'd0);
    chk("b_abort_idata", idata_b, 32'd0);
    ld_vld_b = 1'b1; ld_last_b = 1'b1; ld_data_b = 32'h4444_4444; step();
    ld_vld_b = 1'b0; ld_last_b = 1'b0;
    chk("b_reload_done", {31'd0, ld_done_b}, 32'd1);
    step();
    ics_b = 1'b1; iaddr_b = 24'd0; step();
    chk("b_reload_at_zero", idata_b, 32'h4444_4444);
    iaddr_b = 24'd8; step();
    chk("b_partial_kept", idata_b, 32'h3333_3333);
    ics_b = 1'b0;

    // ---------------- Instance A: run mode ----------------
    rst = 1'b1; step(); step();
    rst = 1'b0;
    chk("a_reset_idata", idata, 32'd0);
    chk("a_reset_hold", {31'd0, core_hold}, 32'd0);
    chk("a_reset_rdy", {31'd0, ld_rdy}, 32'd0);
    chk("a_reset_done", {31'd0, ld_done}, 32'd0);
    chk("a_reset_ovf", {31'd0, ld_ovf}, 32'd0);

    // Full 16-word image, value i at word i, no stalls.
    ld_start = 1'b1; ld_base = 24'd0; step();
    ld_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_vld = 1'b1; ld_data = 32'(i); ld_last = (i == 15);
      step();
      model_mem[i] = 32'(i);
      if (i < 15) chk("full_no_early_done", {31'd0, ld_done}, 32'd0);
    end
    ld_vld = 1'b0; ld_last = 1'b0;
    chk("full_done", {31'd0, ld_done}, 32'd1);
    chk("full_done_hold", {31'd0, core_hold}, 32'd1);
    step();
    chk("full_done_once", {31'd0, ld_done}, 32'd0);
    chk("full_hold_low", {31'd0, core_hold}, 32'd0);
    chk("full_ovf", {31'd0, ld_ovf}, 32'd0);

    // Back-to-back sweep, then idle hold.
    ics = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iaddr = 24'(i);
      step();
      chk("sweep", idata, 32'(i));
    end
    ics = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_hold", idata, 32'd15);
    end

    vecs[0] = '{24'h000010, NOP_OP};
    vecs[1] = '{24'h800000, NOP_OP};
    vecs[2] = '{24'h000003, 32'd3};
    vecs[3] = '{24'hFFFFFF, NOP_OP};
    vecs[4] = '{24'h00000F, 32'd15};
    vecs[5] = '{24'h000000, 32'd0};
    for (int i = 0; i < 6; i++) begin
      ics = 1'b1; iaddr = vecs[i].addr;
      step();
      chk($sformatf("vec%0d", i), idata, vecs[i].exp);
    end
    ics = 1'b0;

    // Overflow at end of memory: 2 written, 2 dropped.
    vld_pat = {1, 1, 1, 1};
    load_a(24'd14, 4, 0, 1'b0);
    chk("ovf_mem14", exp_read(24'd14), model_mem[14]);
    for (int i = 0; i < 16; i++) read_a(24'(i), "post_ovf_image");

    // Stalled loader with stray ld_start pulses mid-load.
    vld_pat = {1, 0, 0, 1, 1};
    load_a(24'd5, 3, 0, 1'b1);
    for (int i = 0; i < 16; i++) read_a(24'(i), "post_stall_image");

    // Pointer wraps past the top of the 24-bit space back into memory.
    load_a(24'hFFFFFE, 4, 20, 1'b0);

    // Randomized loads and reads against the reference image.
    for (int r = 0; r < 12; r++) begin
      load_a(24'($urandom_range(20)), int'($urandom_range(6, 1)), 30, 1'($urandom_range(1)));
      for (int k = 0; k < 8; k++) begin
        logic [23:0] a;
        a = ($urandom_range(3) == 0) ? 24'($urandom) : 24'($urandom_range(17));
        read_a(a, "rand_read");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tawas_irom.md
Name: tawas_irom

Overview:
- Instruction memory responder for the Tawas fetch unit; it is the target end of the ics/iaddr/idata instruction interface.
- Serves one 32-bit instruction word per cycle with fixed 1-cycle read latency.
- Includes a streaming program-load port, so a host or boot agent can write the image while the core is held off via core_hold.
- Sits between the fetch stage and the SoC boot path.

Parameters:
- DEPTH_LOG2, 12, log2 of word count; memory holds 2^DEPTH_LOG2 32-bit words.
- BOOT_LOAD, 0, if 1 reset enters LOAD at word 0 with core_hold asserted; if 0 reset enters RUN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ics  in  1  fetch chip select; read issued this cycle
- iaddr  in  24  fetch word address
- idata  out  32  instruction word, registered
- ld_start  in  1  pulse: begin image load
- ld_base  in  24  first word address of load, sampled on ld_start
- ld_vld  in  1  load data beat valid
- ld_last  in  1  final beat marker, qualified by ld_vld
- ld_data  in  32  load data word
- ld_rdy  out  1  module accepts a load beat
- ld_done  out  1  one-cycle pulse: load complete
- ld_ovf  out  1  sticky: at least one beat addressed past memory end
- core_hold  out  1  hold request for core reset/stall; high during load

Behaviour:
Clock and reset:
- Single clock domain. Reset is synchronous and active-high: only registers sampled at the clk edge with rst=1 are reset.
- Memory array contents are not reset.
- Reset values:
  - idata=0, ld_done=0, ld_ovf=0, wr_ptr=0.
  - If BOOT_LOAD=0: state=RUN, core_hold=0, ld_rdy=0.
  - If BOOT_LOAD=1: state=LOAD, core_hold=1, ld_rdy=1.

State machine (RUN, LOAD, DONE):
- RUN:
  - ld_rdy=0, core_hold=0.
  - ld_start=1: next state LOAD, wr_ptr<=ld_base, ld_ovf<=0, core_hold<=1.
- LOAD:
  - ld_rdy=1.
  - Each cycle with ld_vld&&ld_rdy is one beat: if wr_ptr < 2^DEPTH_LOG2 (wr_ptr[23:DEPTH_LOG2]==0), write ld_data to mem[wr_ptr]; otherwise drop the write and set ld_ovf<=1.
  - wr_ptr<=wr_ptr+1 per beat, 24-bit wrapping add.
  - A beat with ld_last=1 moves to DONE.
  - ld_start is ignored in LOAD.
- DONE (1 cycle):
  - ld_rdy=0, ld_done=1, core_hold stays 1.
  - Next state RUN; core_hold=0 from the following cycle.

Read path:
- ics=1 at cycle N with iaddr=A: idata at N+1 equals mem[A] if A is in range, else 32'hC000_0000 (NOP-loop, parks the slice).
- ics=0: idata holds its previous value.
- In LOAD or DONE, reads return 32'hC000_0000 regardless of address, so no read/write collision exists.
- A read issued in the same cycle that the state returns to RUN is served normally.
- Back-to-back reads to any addresses sustain 1 word/cycle.

Timing and width rules:
- ld_done, ld_rdy and core_hold are registered state decodes; no combinational path from ld_vld to ld_rdy.
- Out-of-range check uses the full 24-bit address.

Reset mid-operation:
- Reset during LOAD or DONE aborts the load; the partial image stays in memory and the block returns to its reset state per BOOT_LOAD.

Test Plan:
- Reset with BOOT_LOAD=0, DEPTH_LOG2=4: idata=0, core_hold=0, ld_rdy=0 -> ld_start with ld_base=0, stream 16 beats 32'h0000_0000+i, last on i=15 -> ld_done pulses once exactly 1 cycle after the last beat, core_hold falls the next cycle, ld_ovf=0.
- After that load, ics=1 with iaddr=0,1,...,15 on consecutive cycles -> idata=i on each following cycle. Drop ics for 3 cycles -> idata holds 15.
- Read iaddr=24'h000010 and 24'h800000 with DEPTH_LOG2=4 -> idata=32'hC000_0000 both times; memory is unchanged.
- Load with ld_base=14, 4 beats (AA,BB,CC,DD) -> mem[14]=AA, mem[15]=BB, two beats dropped, ld_ovf=1. The next ld_start clears ld_ovf.
- Stalled loader: ld_vld toggles 1,0,0,1,1 with ld_last on the final beat -> exactly 3 writes at consecutive addresses; ld_start pulsed mid-LOAD has no effect on wr_ptr.
- BOOT_LOAD=1: after reset, core_hold=1 and ld_rdy=1 -> 2 beats with ld_last on the 2nd -> mem[0..1] written, ld_done pulses. Reset asserted mid-load of a second image -> returns to LOAD at wr_ptr=0 with ld_done=0.
